// File: rtl/mdio_pkg.sv
// Shared MDIO Clause-22 definitions: frame codes, field lengths and the
// frame-position state enumeration used by both ends of the link.
package mdio_pkg;

  localparam int FRAME_BITS = 32;

  localparam logic [1:0] ST_CODE  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  // Remaining frame bits minus one, loaded into the counter on entering SKIP.
  // After ST+OP (4 bits) 28 remain; after ST+OP+PHYAD+REGAD (14 bits) 18 remain.
  localparam logic [4:0] SKIP_AFTER_OP    = 5'(FRAME_BITS - 4 - 1);
  localparam logic [4:0] SKIP_AFTER_REGAD = 5'(FRAME_BITS - 14 - 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_ST    = 4'd1,
    S_OP    = 4'd2,
    S_PHYAD = 4'd3,
    S_REGAD = 4'd4,
    S_TA    = 4'd5,
    S_WDATA = 4'd6,
    S_RDATA = 4'd7,
    S_SKIP  = 4'd8
  } mdio_state_e;

  // Only write and read opcodes start a transaction.
  function automatic logic op_valid(input logic [1:0] op);
    return (op == OP_WRITE) || (op == OP_READ);
  endfunction

endpackage

// File: rtl/mdc_edge_detect.sv
// Detects rising and falling edges of mdc in the clk domain.
module mdc_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic mdc,
  output logic mdc_rise,
  output logic mdc_fall
);

  logic mdc_q;

  // Previous-cycle copy of mdc for edge comparison.
  always_ff @(posedge clk) begin
    if (reset) begin
      mdc_q <= 1'b0;
    end else begin
      mdc_q <= mdc;
    end
  end

  assign mdc_rise = mdc & ~mdc_q;
  assign mdc_fall = ~mdc & mdc_q;

endmodule

// File: rtl/mdio_responder.sv
// PHY-side Clause-22 MDIO responder: decodes frames sampled on mdc rises,
// strobes a local register bank and drives read data back on mdc falls.
module mdio_responder
  import mdio_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        mdc,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oe,
  input  logic [4:0]  phy_addr,
  output logic [4:0]  reg_addr,
  output logic [15:0] wr_data,
  output logic        wr_en,
  output logic        rd_en,
  input  logic [15:0] rd_data
);

  logic        mdc_rise;
  logic        mdc_fall;
  mdio_state_e state;
  mdio_state_e state_next;
  logic [4:0]  bit_cnt;
  logic [4:0]  cnt_next;
  logic [1:0]  op_q;
  logic [1:0]  op_now;
  logic [4:0]  addr_sr;
  logic        phy_match;
  logic [15:0] data_sr;
  logic        cap_pending;
  logic        is_read;
  logic        do_rd;
  logic        do_wr;
  logic        drive_ta;
  logic        drive_bit;
  logic        release_line;

  mdc_edge_detect u_edge (
    .clk      (clk),
    .reset    (reset),
    .mdc      (mdc),
    .mdc_rise (mdc_rise),
    .mdc_fall (mdc_fall)
  );

  assign is_read = (op_q == OP_READ);
  assign op_now  = {op_q[0], mdio_in};

  // State and bit-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      bit_cnt <= 5'd0;
    end else begin
      state   <= state_next;
      bit_cnt <= cnt_next;
    end
  end

  // Frame-position sequencing: fields advance on mdc rises, read data on falls.
  always_comb begin
    state_next = state;
    cnt_next   = bit_cnt;
    case (state)
      S_IDLE: begin
        if (mdc_rise && !mdio_in) begin
          state_next = S_ST;
          cnt_next   = 5'd0;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_ST: begin
        if (mdc_rise) begin
          state_next = mdio_in ? S_OP : S_IDLE;
          cnt_next   = 5'd0;
        end else begin
          state_next = S_ST;
        end
      end
      S_OP: begin
        if (mdc_rise && (bit_cnt == 5'd1)) begin
          if (op_valid(op_now)) begin
            state_next = S_PHYAD;
            cnt_next   = 5'd0;
          end else begin
            state_next = S_SKIP;
            cnt_next   = SKIP_AFTER_OP;
          end
        end else if (mdc_rise) begin
          cnt_next = bit_cnt + 5'd1;
        end else begin
          cnt_next = bit_cnt;
        end
      end
      S_PHYAD: begin
        if (mdc_rise && (bit_cnt == 5'd4)) begin
          state_next = S_REGAD;
          cnt_next   = 5'd0;
        end else if (mdc_rise) begin
          cnt_next = bit_cnt + 5'd1;
        end else begin
          cnt_next = bit_cnt;
        end
      end
      S_REGAD: begin
        if (mdc_rise && (bit_cnt == 5'd4)) begin
          if (phy_match) begin
            state_next = S_TA;
            cnt_next   = 5'd0;
          end else begin
            state_next = S_SKIP;
            cnt_next   = SKIP_AFTER_REGAD;
          end
        end else if (mdc_rise) begin
          cnt_next = bit_cnt + 5'd1;
        end else begin
          cnt_next = bit_cnt;
        end
      end
      S_TA: begin
        // Writes leave after the second TA sample; reads after the fall that
        // follows it, when D15 goes onto the line.
        if (!is_read && mdc_rise && (bit_cnt == 5'd1)) begin
          state_next = S_WDATA;
          cnt_next   = 5'd0;
        end else if (mdc_rise) begin
          cnt_next = bit_cnt + 5'd1;
        end else if (is_read && mdc_fall && (bit_cnt == 5'd2)) begin
          state_next = S_RDATA;
          cnt_next   = 5'd0;
        end else begin
          cnt_next = bit_cnt;
        end
      end
      S_WDATA: begin
        if (mdc_rise && (bit_cnt == 5'd15)) begin
          state_next = S_IDLE;
          cnt_next   = 5'd0;
        end else if (mdc_rise) begin
          cnt_next = bit_cnt + 5'd1;
        end else begin
          cnt_next = bit_cnt;
        end
      end
      S_RDATA: begin
        if (mdc_fall && (bit_cnt == 5'd15)) begin
          state_next = S_IDLE;
          cnt_next   = 5'd0;
        end else if (mdc_fall) begin
          cnt_next = bit_cnt + 5'd1;
        end else begin
          cnt_next = bit_cnt;
        end
      end
      S_SKIP: begin
        if (mdc_rise && (bit_cnt == 5'd0)) begin
          state_next = S_IDLE;
        end else if (mdc_rise) begin
          cnt_next = bit_cnt - 5'd1;
        end else begin
          cnt_next = bit_cnt;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = 5'd0;
      end
    endcase
  end

  // Strobe and line-drive decisions for the current clk.
  always_comb begin
    do_rd        = (state == S_REGAD) && mdc_rise && (bit_cnt == 5'd4) && phy_match && is_read;
    do_wr        = (state == S_WDATA) && mdc_rise && (bit_cnt == 5'd15);
    drive_ta     = (state == S_TA) && is_read && mdc_fall && (bit_cnt == 5'd1);
    drive_bit    = ((state == S_TA) && is_read && mdc_fall && (bit_cnt == 5'd2)) ||
                   ((state == S_RDATA) && mdc_fall && (bit_cnt != 5'd15));
    release_line = (state == S_RDATA) && mdc_fall && (bit_cnt == 5'd15);
  end

  // Datapath: field capture, shift register, registered strobes and line drive.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q        <= 2'b00;
      addr_sr     <= 5'd0;
      phy_match   <= 1'b0;
      data_sr     <= 16'd0;
      cap_pending <= 1'b0;
      rd_en       <= 1'b0;
      wr_en       <= 1'b0;
      reg_addr    <= 5'd0;
      wr_data     <= 16'd0;
      mdio_oe     <= 1'b0;
      mdio_out    <= 1'b0;
    end else begin
      rd_en       <= do_rd;
      wr_en       <= do_wr;
      // Bank data is valid the cycle after rd_en, so load one clk later.
      cap_pending <= rd_en;

      if (mdc_rise && (state == S_OP)) begin
        op_q <= op_now;
      end

      if (mdc_rise && ((state == S_PHYAD) || (state == S_REGAD))) begin
        addr_sr <= {addr_sr[3:0], mdio_in};
      end

      if (mdc_rise && (state == S_PHYAD) && (bit_cnt == 5'd4)) begin
        phy_match <= ({addr_sr[3:0], mdio_in} == phy_addr);
      end

      if (do_rd) begin
        reg_addr <= {addr_sr[3:0], mdio_in};
      end else if (do_wr) begin
        reg_addr <= addr_sr;
        wr_data  <= {data_sr[14:0], mdio_in};
      end

      if (cap_pending) begin
        data_sr <= rd_data;
      end else if (mdc_rise && (state == S_WDATA)) begin
        data_sr <= {data_sr[14:0], mdio_in};
      end else if (drive_bit) begin
        data_sr <= {data_sr[14:0], 1'b0};
      end

      if (drive_ta) begin
        mdio_oe  <= 1'b1;
        mdio_out <= 1'b0;
      end else if (drive_bit) begin
        mdio_out <= data_sr[15];
      end else if (release_line) begin
        mdio_oe  <= 1'b0;
        mdio_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mdio_responder.sv
// Self-checking bench for mdio_responder: a bench-side MDIO controller issues
// directed and random Clause-22 frames; a register-bank model predicts strobes
// and read data from frame fields.
module tb_mdio_responder;
  import mdio_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        mdc;
  logic        mdio_in;
  logic        mdio_out;
  logic        mdio_oe;
  logic [4:0]  phy_addr;
  logic [4:0]  reg_addr;
  logic [15:0] wr_data;
  logic        wr_en;
  logic        rd_en;
  logic [15:0] rd_data;

  logic ctrl_oe;
  logic ctrl_bit;

  int errors = 0;
  int checks = 0;

  // Monitor-owned observations
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          oe_cnt = 0;
  bit          both_seen = 1'b0;
  logic [4:0]  last_wr_addr;
  logic [15:0] last_wr_data;
  logic [4:0]  last_rd_addr;
  logic [15:0] bank [32];

  // Reference register contents
  logic [15:0] model_bank [32];

  // Shared line with pull-up: responder, else controller, else idle 1.
  assign mdio_in = mdio_oe ? mdio_out : (ctrl_oe ? ctrl_bit : 1'b1);

  always #5 clk = ~clk;

  mdio_responder dut (
    .clk      (clk),
    .reset    (reset),
    .mdc      (mdc),
    .mdio_in  (mdio_in),
    .mdio_out (mdio_out),
    .mdio_oe  (mdio_oe),
    .phy_addr (phy_addr),
    .reg_addr (reg_addr),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .rd_data  (rd_data)
  );

  function automatic logic [15:0] init_val(input int i);
    return 16'(i * 771) ^ 16'h5A5A;
  endfunction

  // Register bank and strobe monitor, sampled on the falling clk edge.
  initial begin
    rd_data = 16'h0000;
    for (int i = 0; i < 32; i++) bank[i] = init_val(i);
    forever begin
      @(negedge clk);
      if (wr_en && rd_en) both_seen = 1'b1;
      if (mdio_oe) oe_cnt++;
      if (wr_en) begin
        wr_cnt++;
        last_wr_addr = reg_addr;
        last_wr_data = wr_data;
        bank[reg_addr] = wr_data;
      end
      if (rd_en) begin
        rd_cnt++;
        last_rd_addr = reg_addr;
        rd_data = bank[reg_addr];
      end
    end
  end

  // One mdc bit as the controller: set line while mdc low, sample at the rise.
  task automatic clk_bit(input logic drive, input logic val,
                         output logic sampled, output logic oe_at_rise);
    @(negedge clk);
    ctrl_oe  = drive;
    ctrl_bit = val;
    repeat (3) @(negedge clk);
    sampled    = mdio_in;
    oe_at_rise = mdio_oe;
    mdc = 1'b1;
    repeat (4) @(negedge clk);
    mdc = 1'b0;
  endtask

  // Full frame plus prediction and checks. abort_bit >= 0 resets the DUT
  // just before that data bit of a read.
  task automatic do_frame(input string tag, input logic [1:0] op, input logic [4:0] phy,
                          input logic [4:0] regad, input logic [15:0] data,
                          input int pre, input int abort_bit);
    int          wr0 = wr_cnt;
    int          rd0 = rd_cnt;
    int          oe0 = oe_cnt;
    logic        s, o;
    logic        ta1_oe, ta2_oe, ta2_line;
    logic [15:0] got = 16'h0000;
    logic [15:0] hdr;
    bit          exp_wr, exp_rd, aborted;
    aborted = 1'b0;
    exp_wr = (op == OP_WRITE) && (phy == phy_addr);
    exp_rd = (op == OP_READ)  && (phy == phy_addr);
    hdr = {ST_CODE, op, phy, regad, 2'b10};
    for (int i = 0; i < pre; i++) clk_bit(1'b1, 1'b1, s, o);
    for (int i = 15; i >= 2; i--) clk_bit(1'b1, hdr[i], s, o);
    if (op == OP_READ) begin
      clk_bit(1'b0, 1'b0, s, o);
      ta1_oe = o;
      clk_bit(1'b0, 1'b0, s, o);
      ta2_oe = o;
      ta2_line = s;
      for (int i = 15; i >= 0; i--) begin
        if (i == abort_bit) begin
          aborted = 1'b1;
          checks++;
          if (mdio_oe !== 1'b1) begin errors++; $display("FAIL %s oe_before_reset: got %b want 1", tag, mdio_oe); end
          @(negedge clk);
          reset = 1'b1;
          @(negedge clk);
          checks++;
          if (mdio_oe !== 1'b0) begin errors++; $display("FAIL %s oe_in_reset: got %b want 0", tag, mdio_oe); end
          reset = 1'b0;
          break;
        end
        clk_bit(1'b0, 1'b0, s, o);
        got[i] = s;
      end
    end else begin
      clk_bit(1'b1, 1'b1, s, o);
      clk_bit(1'b1, 1'b0, s, o);
      for (int i = 15; i >= 0; i--) clk_bit(1'b1, data[i], s, o);
    end
    ctrl_oe = 1'b0;
    repeat (3) @(negedge clk);

    if (exp_wr) model_bank[regad] = data;

    checks++;
    if ((wr_cnt - wr0) != (exp_wr ? 1 : 0)) begin
      errors++; $display("FAIL %s wr_en_count: got %0d want %0d", tag, wr_cnt - wr0, exp_wr ? 1 : 0);
    end
    checks++;
    if ((rd_cnt - rd0) != (exp_rd ? 1 : 0)) begin
      errors++; $display("FAIL %s rd_en_count: got %0d want %0d", tag, rd_cnt - rd0, exp_rd ? 1 : 0);
    end
    if (exp_wr) begin
      checks++;
      if (last_wr_addr !== regad) begin errors++; $display("FAIL %s wr_addr: got %0d want %0d", tag, last_wr_addr, regad); end
      checks++;
      if (last_wr_data !== data) begin errors++; $display("FAIL %s wr_data: got %h want %h", tag, last_wr_data, data); end
    end
    if (exp_rd) begin
      checks++;
      if (last_rd_addr !== regad) begin errors++; $display("FAIL %s rd_addr: got %0d want %0d", tag, last_rd_addr, regad); end
      if (!aborted) begin
        checks++;
        if (ta1_oe !== 1'b0 || ta2_oe !== 1'b1 || ta2_line !== 1'b0) begin
          errors++; $display("FAIL %s turnaround: got oe1=%b oe2=%b ta=%b want 0 1 0", tag, ta1_oe, ta2_oe, ta2_line);
        end
        checks++;
        if (got !== model_bank[regad]) begin errors++; $display("FAIL %s read_data: got %h want %h", tag, got, model_bank[regad]); end
        checks++;
        if (mdio_oe !== 1'b0) begin errors++; $display("FAIL %s oe_after_read: got %b want 0", tag, mdio_oe); end
      end
    end else begin
      checks++;
      if (oe_cnt != oe0) begin errors++; $display("FAIL %s line_driven: got %0d cycles want 0", tag, oe_cnt - oe0); end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (mdio_oe !== 1'b0 || mdio_out !== 1'b0) begin
      errors++; $display("FAIL reset_line: got oe=%b out=%b want 0 0", mdio_oe, mdio_out);
    end
    checks++;
    if (wr_en !== 1'b0 || rd_en !== 1'b0) begin
      errors++; $display("FAIL reset_strobes: got wr=%b rd=%b want 0 0", wr_en, rd_en);
    end
    checks++;
    if (reg_addr !== 5'd0 || wr_data !== 16'd0) begin
      errors++; $display("FAIL reset_regs: got addr=%h data=%h want 0 0", reg_addr, wr_data);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    phy_addr = 5'd1;
    do_frame("write", OP_WRITE, 5'd1, 5'd2, 16'hABCD, 32, -1);
  endtask

  task automatic test_read();
    phy_addr = 5'd3;
    do_frame("read_setup", OP_WRITE, 5'd3, 5'd4, 16'h1234, 32, -1);
    do_frame("read", OP_READ, 5'd3, 5'd4, 16'h0000, 8, -1);
  endtask

  task automatic test_mismatch();
    phy_addr = 5'd5;
    do_frame("mismatch_wr", OP_WRITE, 5'd1, 5'd7, 16'h0000, 32, -1);
    do_frame("mismatch_rd", OP_READ, 5'd1, 5'd2, 16'h0000, 4, -1);
    do_frame("match_wr", OP_WRITE, 5'd5, 5'd7, 16'h8001, 0, -1);
    do_frame("match_rd", OP_READ, 5'd5, 5'd7, 16'h0000, 0, -1);
  endtask

  task automatic test_invalid_op();
    phy_addr = 5'd5;
    do_frame("op11", 2'b11, 5'd5, 5'd3, 16'h0000, 32, -1);
    do_frame("op00", 2'b00, 5'd5, 5'd3, 16'h0000, 0, -1);
    do_frame("after_skip_rd", OP_READ, 5'd5, 5'd2, 16'h0000, 0, -1);
  endtask

  task automatic test_reset_mid_read();
    phy_addr = 5'd6;
    do_frame("abort_rd", OP_READ, 5'd6, 5'd9, 16'h0000, 8, 8);
    do_frame("post_reset_wr", OP_WRITE, 5'd6, 5'd9, 16'hC3A5, 8, -1);
    do_frame("post_reset_rd", OP_READ, 5'd6, 5'd9, 16'h0000, 0, -1);
  endtask

  task automatic test_back_to_back();
    phy_addr = 5'd2;
    do_frame("b2b_wr", OP_WRITE, 5'd2, 5'd17, 16'h5AA5, 4, -1);
    do_frame("b2b_rd", OP_READ, 5'd2, 5'd17, 16'h0000, 0, -1);
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [4:0] phy;
    int         r;
    phy_addr = 5'd9;
    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 9);
      op = (r < 4) ? OP_WRITE : (r < 8) ? OP_READ : (r == 8) ? 2'b00 : 2'b11;
      phy = ($urandom_range(0, 2) != 0) ? phy_addr : 5'($urandom_range(0, 31));
      do_frame("random", op, phy, 5'($urandom_range(0, 31)), 16'($urandom),
               $urandom_range(0, 3), -1);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model_bank[i] = init_val(i);
    reset    = 1'b1;
    mdc      = 1'b0;
    ctrl_oe  = 1'b0;
    ctrl_bit = 1'b1;
    phy_addr = 5'd0;
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_invalid_op();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    checks++;
    if (both_seen) begin errors++; $display("FAIL strobe_exclusive: got both wr_en and rd_en high want never"); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
